// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module  : mem_port_arbiter
// Brief   : Fetch/data arbiter onto a single-port memory with starvation guard.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 16,
  parameter int STARVE_LIM = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  // instruction-fetch port
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  // data port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  // single-port memory
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam logic [1:0] C_STARVE_LIM = 2'(STARVE_LIM);

  logic [1:0] r_starve_cnt;
  logic       r_rd_pend_i;
  logic       r_rd_pend_d;

  logic       w_active;
  logic       w_starved;
  logic       w_i_gnt;
  logic       w_d_gnt;
  logic [1:0] w_starve_nxt;

  // Grants are combinational from the request; reset also masks them so that
  // every output reads zero while rst_n is low.
  always_comb begin
    w_active  = enable & rst_n;
    w_starved = i_req & (r_starve_cnt == C_STARVE_LIM);
    w_i_gnt   = w_active & i_req & (~d_req | w_starved);
    w_d_gnt   = w_active & d_req & ~w_i_gnt;
  end

  always_comb begin
    w_starve_nxt = r_starve_cnt;
    if (enable) begin
      if (!i_req || w_i_gnt) begin
        w_starve_nxt = 2'd0;
      end else if (r_starve_cnt != C_STARVE_LIM) begin
        w_starve_nxt = r_starve_cnt + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= 2'd0;
      r_rd_pend_i  <= 1'b0;
      r_rd_pend_d  <= 1'b0;
    end else begin
      r_starve_cnt <= w_starve_nxt;
      r_rd_pend_i  <= w_i_gnt;
      r_rd_pend_d  <= w_d_gnt & ~d_we;
    end
  end

  always_comb begin
    i_gnt   = w_i_gnt;
    d_gnt   = w_d_gnt;
    m_en    = w_i_gnt | w_d_gnt;
    m_we    = w_d_gnt & d_we;
    m_addr  = '0;
    m_wdata = '0;
    if (w_i_gnt) begin
      m_addr = i_addr;
    end else if (w_d_gnt) begin
      m_addr  = d_addr;
      m_wdata = d_wdata;
    end
  end

  // Read data is steered from the memory for exactly the cycle after issue.
  always_comb begin
    i_rvalid = r_rd_pend_i;
    d_rvalid = r_rd_pend_d;
    i_rdata  = r_rd_pend_i ? m_rdata : '0;
    d_rdata  = r_rd_pend_d ? m_rdata : '0;
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module  : tb_mem_port_arbiter
// Brief   : Directed scoreboard bench for mem_port_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        i_req;
  logic [7:0]  i_addr;
  logic        i_gnt, i_rvalid;
  logic [15:0] i_rdata;
  logic        d_req, d_we;
  logic [7:0]  d_addr;
  logic [15:0] d_wdata;
  logic        d_gnt, d_rvalid;
  logic [15:0] d_rdata;
  logic        m_en, m_we;
  logic [7:0]  m_addr;
  logic [15:0] m_wdata;
  logic [15:0] m_rdata;

  typedef struct packed {
    logic        port_d;
    logic [15:0] data;
  } rsp_t;

  rsp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] mem [256];

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(16), .STARVE_LIM(3)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  // Memory model: one-cycle read latency.
  always @(posedge clk) begin
    if (m_en && m_we) mem[m_addr] <= m_wdata;
    if (m_en && !m_we) m_rdata <= mem[m_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever a read result is presented.
  always @(negedge clk) begin
    rsp_t r;
    if (i_rvalid || d_rvalid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rvalid", {30'd0, i_rvalid, d_rvalid}, 32'd0);
      end else begin
        r = exp_q.pop_front();
        chk("rvalid_port", {30'd0, i_rvalid, d_rvalid}, r.port_d ? 32'd1 : 32'd2);
        chk("rdata", r.port_d ? {16'd0, d_rdata} : {16'd0, i_rdata}, {16'd0, r.data});
      end
    end
    if (!i_rvalid) chk("i_rdata_idle", {16'd0, i_rdata}, 32'd0);
    if (!d_rvalid) chk("d_rdata_idle", {16'd0, d_rdata}, 32'd0);
  end

  task automatic drive(input logic ir, input logic [7:0] ia,
                       input logic dr, input logic dw, input logic [7:0] da,
                       input logic [15:0] dwd);
    i_req = ir; i_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_gnt(input string name, input logic eg_i, input logic eg_d,
                         input logic [7:0] ea);
    @(negedge clk);
    chk({name, "_i_gnt"}, {31'd0, i_gnt}, {31'd0, eg_i});
    chk({name, "_d_gnt"}, {31'd0, d_gnt}, {31'd0, eg_d});
    chk({name, "_m_en"}, {31'd0, m_en}, {31'd0, eg_i | eg_d});
    chk({name, "_m_addr"}, {24'd0, m_addr}, {24'd0, ea});
  endtask

  task automatic chk_all_zero(input string name);
    @(negedge clk);
    chk(name, {i_gnt, d_gnt, i_rvalid, d_rvalid, m_en, m_we, 26'd0}, 32'd0);
    chk({name, "_bus"}, {m_addr, m_wdata, 8'd0}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = {8'hC0, 8'(a)};
    mem[8'h04] = 16'hE200; mem[8'h05] = 16'h0505; mem[8'h06] = 16'h0606;
    mem[8'h07] = 16'h0707; mem[8'h10] = 16'hA5A5; mem[8'h11] = 16'h1111;
    mem[8'h12] = 16'h1212;

    // Reset: requests present but everything must be quiet.
    rst_n = 1'b0; enable = 1'b1;
    drive(1'b1, 8'h04, 1'b1, 1'b0, 8'h10, 16'h0);
    chk_all_zero("reset");
    next_cycle();

    // Fetch only, first cycle after release.
    rst_n = 1'b1;
    drive(1'b1, 8'h04, 1'b0, 1'b0, 8'h00, 16'h0);
    chk_gnt("fetch", 1'b1, 1'b0, 8'h04);
    chk("fetch_m_we", {31'd0, m_we}, 32'd0);
    exp_q.push_back('{1'b0, 16'hE200});
    next_cycle();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0);
    chk_gnt("idle1", 1'b0, 1'b0, 8'h00);
    next_cycle();

    // Data write: no read result may follow.
    drive(1'b0, 8'h00, 1'b1, 1'b1, 8'h20, 16'h1234);
    chk_gnt("write", 1'b0, 1'b1, 8'h20);
    chk("write_m_we", {31'd0, m_we}, 32'd1);
    chk("write_m_wdata", {16'd0, m_wdata}, 32'h1234);
    next_cycle();

    // Simultaneous requests: data first, fetch next cycle back-to-back.
    drive(1'b1, 8'h05, 1'b1, 1'b0, 8'h10, 16'h0);
    chk_gnt("simul_d", 1'b0, 1'b1, 8'h10);
    chk("simul_m_wdata", {16'd0, m_wdata}, 32'd0);
    exp_q.push_back('{1'b1, 16'hA5A5});
    next_cycle();
    drive(1'b1, 8'h05, 1'b0, 1'b0, 8'h00, 16'h0);
    chk_gnt("simul_i", 1'b1, 1'b0, 8'h05);
    exp_q.push_back('{1'b0, 16'h0505});
    next_cycle();

    // Read back the earlier write.
    drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h20, 16'h0);
    chk_gnt("readback", 1'b0, 1'b1, 8'h20);
    exp_q.push_back('{1'b1, 16'h1234});
    next_cycle();

    // Starvation: three data grants, then a forced fetch, repeating.
    drive(1'b1, 8'h06, 1'b1, 1'b0, 8'h11, 16'h0);
    for (int k = 0; k < 8; k++) begin
      if ((k % 4) == 3) begin
        chk_gnt("starve_i", 1'b1, 1'b0, 8'h06);
        exp_q.push_back('{1'b0, 16'h0606});
      end else begin
        chk_gnt("starve_d", 1'b0, 1'b1, 8'h11);
        exp_q.push_back('{1'b1, 16'h1111});
      end
      next_cycle();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0);
    next_cycle();

    // Enable drop: starve count (1) is held, in-flight read still returns.
    drive(1'b1, 8'h07, 1'b1, 1'b0, 8'h12, 16'h0);
    chk_gnt("pre_dis", 1'b0, 1'b1, 8'h12);
    exp_q.push_back('{1'b1, 16'h1212});
    next_cycle();
    enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk_gnt("disabled", 1'b0, 1'b0, 8'h00);
      next_cycle();
    end
    enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin
        chk_gnt("reen_i", 1'b1, 1'b0, 8'h07);
        exp_q.push_back('{1'b0, 16'h0707});
      end else begin
        chk_gnt("reen_d", 1'b0, 1'b1, 8'h12);
        exp_q.push_back('{1'b1, 16'h1212});
      end
      next_cycle();
    end

    // Reset one cycle after a fetch grant discards the pending read.
    drive(1'b1, 8'h04, 1'b0, 1'b0, 8'h00, 16'h0);
    chk_gnt("pre_rst", 1'b1, 1'b0, 8'h04);
    next_cycle();
    rst_n = 1'b0;
    chk_all_zero("rst_inflight");
    next_cycle();
    chk_all_zero("rst_hold");
    next_cycle();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0);
    rst_n = 1'b1;
    chk_all_zero("post_rst");
    next_cycle();
    chk_all_zero("post_rst2");
    next_cycle();

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, 8, address width of all ports.
REQ-002 Parameter DATA_W, 16, data width of all ports.
REQ-003 Parameter STARVE_LIM, 3, number of consecutive denied fetch cycles that forces a fetch grant.
REQ-004 clock  in  1  single clock; all state SHALL update on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 enable  in  1  when 0, no new grants; in-flight read data still returned.
REQ-007 i_req  in  1  instruction-fetch read request.
REQ-008 i_addr  in  ADDR_W  fetch address.
REQ-009 i_gnt  out  1  fetch issued this cycle.
REQ-010 i_rvalid  out  1  fetch data valid on i_rdata.
REQ-011 i_rdata  out  DATA_W  fetch read data.
REQ-012 d_req  in  1  data-port request.
REQ-013 d_we  in  1  1 = write, 0 = read.
REQ-014 d_addr  in  ADDR_W  data address.
REQ-015 d_wdata  in  DATA_W  write data.
REQ-016 d_gnt  out  1  data access issued this cycle.
REQ-017 d_rvalid  out  1  data read result valid on d_rdata.
REQ-018 d_rdata  out  DATA_W  data read result.
REQ-019 m_en, m_we  out  1 each  single-port memory enable / write strobe.
REQ-020 m_addr, m_wdata  out  ADDR_W / DATA_W  memory address / write data.
REQ-021 m_rdata  in  DATA_W  memory read data, valid the cycle after a read issue.

Function
REQ-022 Grant is the handshake: a request is accepted in the cycle its gnt is 1; requester may change req/addr/data on the next cycle.
REQ-023 At most one of i_gnt, d_gnt SHALL be 1 in any cycle; gnt SHALL be 0 whenever enable=0 or the matching req=0.
REQ-024 Default priority: d_req wins over i_req.
REQ-025 2-bit register starve_cnt: +1 each cycle i_req=1 and i_gnt=0 (enable=1), saturating at STARVE_LIM; cleared on i_gnt or i_req=0; held while enable=0.
REQ-026 When starve_cnt==STARVE_LIM and i_req=1, the fetch SHALL win over d_req that cycle.
REQ-027 On any grant: m_en=1, m_addr=granted addr; m_we=d_we and m_wdata=d_wdata on data grant, m_we=0 on fetch grant; otherwise m_en=m_we=0, m_addr/m_wdata=0.
REQ-028 Registered tag rd_pend[1:0] records (fetch read, data read) issued; next cycle the matching rvalid=1 for exactly one cycle and its rdata=m_rdata; non-valid rdata=0.
REQ-029 Data writes SHALL produce no d_rvalid.
REQ-030 Back-to-back grants every cycle SHALL be sustained (throughput 1 access/cycle); read latency fixed at 1 cycle.
REQ-031 Dropping enable mid-stream: grant cycle before enable fall still yields its rvalid the following cycle.

Reset
REQ-032 While reset=0: i_gnt, d_gnt, i_rvalid, d_rvalid, m_en, m_we = 0; m_addr, m_wdata, i_rdata, d_rdata = 0; starve_cnt=0; rd_pend=0.
REQ-033 Reset asserted with a read in flight SHALL discard it: no rvalid after reset release.
REQ-034 First grant possible in the first rising edge cycle after reset=1 with enable=1.

Verification
REQ-035 Fetch only: i_req=1, i_addr=0x04, m_rdata next cycle=0xE200 -> i_gnt=1 cycle N, i_rvalid=1, i_rdata=0xE200 cycle N+1.
REQ-036 Simultaneous: i_req=1 @0x05, d_req=1 read @0x10 -> d_gnt=1, m_addr=0x10 first; i_gnt=1, m_addr=0x05 next cycle when d_req drops.
REQ-037 Starvation: i_req=1 and d_req=1 held continuously -> d_gnt cycles 1-3, i_gnt cycle 4, starve_cnt back to 0, pattern repeats.
REQ-038 Write: d_req=1, d_we=1, d_addr=0x20, d_wdata=0x1234 -> m_en=1, m_we=1, m_addr=0x20, m_wdata=0x1234 same cycle; no d_rvalid.
REQ-039 enable=0 with i_req=1 for 5 cycles -> no grants, starve_cnt unchanged, m_en=0; grant on first cycle enable=1.
REQ-040 Reset low one cycle after fetch grant -> i_rvalid stays 0, all outputs 0 until release.
